// File: rtl/pes_usr_gen.sv
// Universal shift register with single-operation mode and counted bursts.
// A burst latches its operation and length, then applies that operation once per enabled edge.
module pes_usr_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CW-1:0]    cnt_in,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] v,
                                                  input logic             sr,
                                                  input logic             sl,
                                                  input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] r;
        r = v;
        unique case (op)
            3'b000: r = v;
            3'b001: r = {sr, v[WIDTH-1:1]};
            3'b010: r = {v[WIDTH-2:0], sl};
            3'b011: r = p;
            3'b100: r = {v[0], v[WIDTH-1:1]};
            3'b101: r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b110: r = {v[WIDTH-1], v[WIDTH-1:1]};
            3'b111: r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        if (en) begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        // Start edge only arms the burst; q is untouched.
                        op_d    = mode;
                        cnt_d   = cnt_in;
                        state_d = (cnt_in == '0) ? StDone : StRun;
                    end else begin
                        q_d     = apply_op(mode, q_q, sin_r, sin_l, pin);
                        state_d = StIdle;
                    end
                end
                StRun: begin
                    q_d   = apply_op(op_q, q_q, sin_r, sin_l, pin);
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= '0;
            op_q    <= 3'b000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = (state_q == StRun);
    // A pending done is held in StDone and only shown while enabled.
    assign done   = (state_q == StDone) && en;

endmodule
